// File: rtl/pipeadd3_accum_pkg.sv
// Shared constants and state encoding for the pipeline-adder block accumulator.
// The adder latency lives here so the adder and this consumer agree on it.
package pipeadd3_accum_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefAccWidth = 24;
  localparam int unsigned DefCount    = 4;
  localparam int unsigned AdderLat    = 2;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } acc_state_e;

endpackage

// File: rtl/pipeadd3_accum_valid_delay_line.sv
// Shift register that delays the launch strobe so it lines up with the adder output.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic s_valid
);

  logic [DEPTH-1:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  assign s_valid = shift_q[DEPTH-1];

endmodule

// File: rtl/pipeadd3_accum.sv
// Accumulates COUNT aligned adder sums per block and presents each block result
// on a valid/ready output register, holding one completed block under backpressure.
module pipeadd3_accum
  import pipeadd3_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned COUNT     = DefCount,
  parameter int unsigned LAT       = AdderLat
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf,
  output logic                 drop_err
);

  localparam int unsigned CntW = $clog2(COUNT);
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

  logic s_valid;

  valid_delay_line #(
    .DEPTH (LAT)
  ) u_valid_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .s_valid  (s_valid)
  );

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_blk_q, ovf_blk_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 drop_err_q, drop_err_d;

  logic [ACC_WIDTH:0]   add_full;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;

  assign add_full  = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(sum)};
  assign add_sum   = add_full[ACC_WIDTH-1:0];
  assign add_carry = add_full[ACC_WIDTH];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_blk_d   = ovf_blk_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    drop_err_d  = drop_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StAccum: begin
        if (s_valid) begin
          if (cnt_q == CntLast) begin
            if (!out_valid_q || out_ready) begin
              out_valid_d = 1'b1;
              out_acc_d   = add_sum;
              out_ovf_d   = ovf_blk_q | add_carry;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_blk_d   = 1'b0;
            end else begin
              // Output register busy: park the finished block in the accumulator.
              acc_d     = add_sum;
              ovf_blk_d = ovf_blk_q | add_carry;
              state_d   = StHold;
            end
          end else begin
            acc_d     = add_sum;
            cnt_d     = cnt_q + CntW'(1);
            ovf_blk_d = ovf_blk_q | add_carry;
          end
        end
      end
      StHold: begin
        if (s_valid) begin
          drop_err_d = 1'b1;
        end
        if (out_ready) begin
          out_valid_d = 1'b1;
          out_acc_d   = acc_q;
          out_ovf_d   = ovf_blk_q;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_blk_d   = 1'b0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_blk_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_blk_q   <= ovf_blk_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_pipeadd3_accum.sv
// Randomised bench for pipeadd3_accum: a default instance and a narrow COUNT=2 instance
// share stimulus and are checked every cycle against an integer-arithmetic block model.
module tb_pipeadd3_accum;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] sum;

  logic        in_ready0, out_valid0, out_ovf0, drop_err0;
  logic [23:0] out_acc0;
  logic        in_ready1, out_valid1, out_ovf1, drop_err1;
  logic [15:0] out_acc1;

  pipeadd3_accum dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .sum       (sum),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_acc   (out_acc0),
    .out_ovf   (out_ovf0),
    .drop_err  (drop_err0)
  );

  pipeadd3_accum #(
    .WIDTH     (16),
    .ACC_WIDTH (16),
    .COUNT     (2),
    .LAT       (LAT)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .sum       (sum),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_acc   (out_acc1),
    .out_ovf   (out_ovf1),
    .drop_err  (drop_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Launch history: index 0 is this cycle's launch, index LAT is the one now aligned.
  bit          hv [LAT+1];
  logic [15:0] hd [LAT+1];

  // Block model per instance: running total kept unbounded, reduced only on publish.
  int          p_cnt [2] = '{4, 2};
  longint      p_mod [2] = '{64'd1 << 24, 64'd1 << 16};
  longint      m_total [2];
  int          m_cnt [2];
  bit          m_parked [2];
  bit          m_ov [2];
  longint      m_oacc [2];
  bit          m_oovf [2];
  bit          m_drop [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_total[i] = 0; m_cnt[i] = 0; m_parked[i] = 0; m_ov[i] = 0;
      m_oacc[i] = 0; m_oovf[i] = 0; m_drop[i] = 0;
    end
    for (int j = 0; j <= LAT; j++) begin
      hv[j] = 0; hd[j] = '0;
    end
  endtask

  task automatic publish(input int i);
    m_oacc[i]   = m_total[i] % p_mod[i];
    m_oovf[i]   = (m_total[i] >= p_mod[i]);
    m_ov[i]     = 1;
    m_total[i]  = 0;
    m_cnt[i]    = 0;
    m_parked[i] = 0;
  endtask

  task automatic model_step(input int i, input bit sv, input longint x, input bit ordy);
    bit taken;
    bit loaded;
    taken  = m_ov[i] && ordy;
    loaded = 0;
    if (m_parked[i]) begin
      if (sv) m_drop[i] = 1;
      if (ordy) publish(i);
    end else begin
      if (sv) begin
        m_total[i] += x;
        m_cnt[i]++;
        if (m_cnt[i] == p_cnt[i]) begin
          if (!m_ov[i] || taken) begin
            publish(i);
            loaded = 1;
          end else begin
            m_parked[i] = 1;
          end
        end
      end
      if (taken && !loaded) m_ov[i] = 0;
    end
  endtask

  task automatic check_dut(input int i, input logic ov, input logic ir, input logic de,
                           input logic [63:0] oacc, input logic oovf);
    check($sformatf("d%0d_out_valid", i), {63'd0, ov}, {63'd0, m_ov[i]});
    check($sformatf("d%0d_in_ready", i), {63'd0, ir}, {63'd0, !m_parked[i]});
    check($sformatf("d%0d_drop_err", i), {63'd0, de}, {63'd0, m_drop[i]});
    if (m_ov[i]) begin
      check($sformatf("d%0d_out_acc", i), oacc, m_oacc[i]);
      check($sformatf("d%0d_out_ovf", i), {63'd0, oovf}, {63'd0, m_oovf[i]});
    end
  endtask

  // One clock: drive launch and aligned sum, let the edge pass, update model, compare.
  task automatic cycle(input bit v, input logic [15:0] d, input bit ordy);
    for (int j = LAT; j > 0; j--) begin
      hv[j] = hv[j-1];
      hd[j] = hd[j-1];
    end
    hv[0]     = v;
    hd[0]     = d;
    in_valid  = v;
    out_ready = ordy;
    sum       = hv[LAT] ? hd[LAT] : 16'hDEAD;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, hv[LAT], longint'(hd[LAT]), ordy);
    @(negedge clk);
    check_dut(0, out_valid0, in_ready0, drop_err0, {40'd0, out_acc0}, out_ovf0);
    check_dut(1, out_valid1, in_ready1, drop_err1, {48'd0, out_acc1}, out_ovf1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ov0"}, {63'd0, out_valid0}, 64'd0);
    check({tag, "_acc0"}, {40'd0, out_acc0}, 64'd0);
    check({tag, "_ovf0"}, {63'd0, out_ovf0}, 64'd0);
    check({tag, "_de0"}, {63'd0, drop_err0}, 64'd0);
    check({tag, "_ir0"}, {63'd0, in_ready0}, 64'd1);
    check({tag, "_ov1"}, {63'd0, out_valid1}, 64'd0);
    check({tag, "_acc1"}, {48'd0, out_acc1}, 64'd0);
    check({tag, "_de1"}, {63'd0, drop_err1}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = 16'h0000;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic block 1,2,3,4 with a ready consumer.
    for (int k = 1; k <= 4; k++) cycle(1, 16'(k), 1);
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1);

    // Back-to-back blocks of fives.
    for (int k = 0; k < 8; k++) cycle(1, 16'd5, 1);
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1);

    // Backpressure: two blocks of ones, then a launch into HOLD, then drain.
    for (int k = 0; k < 8; k++) cycle(1, 16'd1, 0);
    for (int k = 0; k < 3; k++) cycle(0, 16'h0, 0);
    cycle(1, 16'd1, 0);
    for (int k = 0; k < 4; k++) cycle(0, 16'h0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1);

    // Overflow on the 16-bit instance; the 24-bit one sums all four.
    cycle(1, 16'hFFFF, 1);
    cycle(1, 16'h0002, 1);
    cycle(1, 16'h0001, 1);
    cycle(1, 16'h0001, 1);
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1);

    // Random launches with idle gaps and random backpressure.
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 12; k++) cycle(0, 16'h0, 1);

    // Async reset after two of four samples, then a clean block.
    cycle(1, 16'd1, 1);
    cycle(1, 16'd2, 1);
    cycle(0, 16'h0, 1);
    cycle(0, 16'h0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) cycle(1, 16'(k), 1);
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
